// File: rtl/nw_cell_scorer_if.sv
// ============================================================================
// nw_cell_scorer_if : start/character/neighbour inputs and RAM write-back bus
// Revision: 1.0
// ============================================================================
`default_nettype none

interface nw_cell_scorer_if #(
    parameter int BitAddr = 3
);
    logic                    start;
    logic [1:0]              char_a;
    logic [1:0]              char_b;
    logic signed [8:0]       diag;
    logic signed [8:0]       up;
    logic signed [8:0]       left;
    logic [BitAddr:0]        i;
    logic [BitAddr:0]        j;
    logic                    en_read;
    logic                    en_ins;
    logic                    we;
    logic signed [8:0]       max;
    logic [1:0]              dir;
    logic                    dir_valid;
    logic                    busy;
    logic                    done;

    modport master (
        input  start, char_a, char_b, diag, up, left,
        output i, j, en_read, en_ins, we, max, dir, dir_valid, busy, done
    );

    modport slave (
        output start, char_a, char_b, diag, up, left,
        input  i, j, en_read, en_ins, we, max, dir, dir_valid, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/nw_cell_scorer.sv
// ============================================================================
// nw_cell_scorer : Needleman-Wunsch cell fill FSM and score arithmetic.
// Optional macro NW_LOCAL_ALIGN_EN selects Smith-Waterman (local) clamping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module nw_cell_scorer #(
    parameter int N        = 4,
    parameter int BitAddr  = $clog2(N + 1),
    parameter int MATCH    = 1,
    parameter int MISMATCH = -1,
    parameter int GAP      = -2
) (
    input  wire logic        clk,
    input  wire logic        rst,
    nw_cell_scorer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CALC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic signed [9:0] C_MATCH    = 10'(MATCH);
    localparam logic signed [9:0] C_MISMATCH = 10'(MISMATCH);
    localparam logic signed [9:0] C_GAP      = 10'(GAP);
    localparam logic [BitAddr:0]  C_LAST     = (BitAddr + 1)'(N - 1);
    localparam logic [BitAddr:0]  C_ONE      = (BitAddr + 1)'(1);

    state_t            state_q, state_d;
    logic [BitAddr:0]  i_q, i_d, j_q, j_d;
    logic signed [8:0] max_q, max_d;
    logic [1:0]        dir_q, dir_d;
    logic              en_read_q, en_read_d;
    logic              en_ins_q, en_ins_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic signed [9:0] d_sum, u_sum, l_sum;
    logic signed [8:0] d_sat, u_sat, l_sat, best;
    logic [1:0]        best_dir;

    function automatic logic signed [8:0] sat9(input logic signed [9:0] v);
        if (v > 10'sd255)
            return 9'sd255;
        else if (v < -10'sd256)
            return -9'sd256;
        else
            return v[8:0];
    endfunction

    // Strict '>' gives the diag > up > left tie priority.
    always_comb begin
        d_sum = $signed({bus.diag[8], bus.diag})
              + ((bus.char_a == bus.char_b) ? C_MATCH : C_MISMATCH);
        u_sum = $signed({bus.up[8], bus.up})     + C_GAP;
        l_sum = $signed({bus.left[8], bus.left}) + C_GAP;
        d_sat = sat9(d_sum);
        u_sat = sat9(u_sum);
        l_sat = sat9(l_sum);
        best     = d_sat;
        best_dir = 2'b00;
        if (u_sat > best) begin
            best     = u_sat;
            best_dir = 2'b01;
        end
        if (l_sat > best) begin
            best     = l_sat;
            best_dir = 2'b10;
        end
`ifdef NW_LOCAL_ALIGN_EN
        if (best < 9'sd0) begin
            best     = 9'sd0;
            best_dir = 2'b11;
        end
`else
`endif
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        max_d   = max_q;
        dir_d   = dir_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    i_d     = '0;
                    j_d     = '0;
                    state_d = S_READ;
                end
            end
            S_READ:  state_d = S_CALC;
            S_CALC: begin
                max_d   = best;
                dir_d   = best_dir;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (j_q < C_LAST) begin
                    j_d     = j_q + C_ONE;
                    state_d = S_READ;
                end else if (i_q < C_LAST) begin
                    j_d     = '0;
                    i_d     = i_q + C_ONE;
                    state_d = S_READ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Strobes decode the next state so every output comes straight from a flop.
        en_read_d = (state_d == S_READ);
        en_ins_d  = (state_d == S_WRITE);
        busy_d    = (state_d == S_READ) || (state_d == S_CALC) || (state_d == S_WRITE);
        done_d    = (state_d == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            max_q     <= '0;
            dir_q     <= 2'b00;
            en_read_q <= 1'b0;
            en_ins_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            max_q     <= max_d;
            dir_q     <= dir_d;
            en_read_q <= en_read_d;
            en_ins_q  <= en_ins_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.i         = i_q;
    assign bus.j         = j_q;
    assign bus.max       = max_q;
    assign bus.dir       = dir_q;
    assign bus.en_read   = en_read_q;
    assign bus.en_ins    = en_ins_q;
    assign bus.we        = en_ins_q;
    assign bus.dir_valid = en_ins_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;

endmodule

`default_nettype wire

// File: tb/tb_nw_cell_scorer.sv
// ============================================================================
// tb_nw_cell_scorer : directed bench for nw_cell_scorer (N=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_nw_cell_scorer;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    nw_cell_scorer_if #(.BitAddr(3)) bus ();

    nw_cell_scorer #(.N(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a fill with constant neighbour inputs, captures the first WRITE, then drains to IDLE.
    task automatic run_first_cell(input logic [8:0] d, input logic [8:0] u, input logic [8:0] l,
                                  input logic [1:0] ca, input logic [1:0] cb,
                                  output logic [8:0] omax, output logic [1:0] odir,
                                  output logic [3:0] oi, output logic [3:0] oj,
                                  output int width, output bit seen);
        bus.diag   = d;
        bus.up     = u;
        bus.left   = l;
        bus.char_a = ca;
        bus.char_b = cb;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        seen  = 1'b0;
        width = 0;
        omax  = '0;
        odir  = '0;
        oi    = '0;
        oj    = '0;
        for (int c = 0; c < 10 && !seen; c++) begin
            if (bus.we) begin
                seen = 1'b1;
                omax = bus.max;
                odir = bus.dir;
                oi   = bus.i;
                oj   = bus.j;
            end else begin
                tick();
            end
        end
        while (seen && bus.we && bus.en_ins && bus.dir_valid && width < 10) begin
            width++;
            tick();
        end
        for (int c = 0; c < 60 && !bus.done; c++) tick();
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b1;
        tick();
        tick();
        total++;
        if ({bus.en_read, bus.en_ins, bus.we, bus.dir_valid, bus.busy, bus.done} !== 6'b0) begin
            bad++;
            $display("FAIL reset_strobes: got %b want 000000",
                     {bus.en_read, bus.en_ins, bus.we, bus.dir_valid, bus.busy, bus.done});
        end
        total++;
        if ({bus.i, bus.j, bus.max, bus.dir} !== 19'b0) begin
            bad++;
            $display("FAIL reset_data: got i=%0d j=%0d max=%h dir=%b want all 0",
                     bus.i, bus.j, bus.max, bus.dir);
        end
        bus.start = 1'b0;
        rst = 1'b1;
        begin
            bit strobe = 1'b0;
            for (int c = 0; c < 5; c++) begin
                tick();
                if (bus.en_read || bus.en_ins || bus.we || bus.busy || bus.done) strobe = 1'b1;
            end
            total++;
            if (strobe !== 1'b0) begin
                bad++;
                $display("FAIL idle_no_strobe: got strobe=%b want 0", strobe);
            end
        end
    endtask

    task automatic test_match();
        logic [8:0] m; logic [1:0] dr; logic [3:0] ii, jj; int w; bit s;
        run_first_cell(9'h000, 9'h1FE, 9'h1FE, 2'b01, 2'b01, m, dr, ii, jj, w, s);
        total++;
        if (!s || m !== 9'd1 || dr !== 2'b00) begin
            bad++;
            $display("FAIL match_cell: got seen=%b max=%h dir=%b want max=001 dir=00", s, m, dr);
        end
        total++;
        if (ii !== 4'd0 || jj !== 4'd0 || w !== 1) begin
            bad++;
            $display("FAIL match_idx_width: got i=%0d j=%0d width=%0d want 0 0 1", ii, jj, w);
        end
    endtask

    task automatic test_tie();
        logic [8:0] m; logic [1:0] dr; logic [3:0] ii, jj; int w; bit s;
        logic [8:0] em; logic [1:0] ed;
`ifdef NW_LOCAL_ALIGN_EN
        em = 9'h000; ed = 2'b11;
`else
        em = 9'h1FF; ed = 2'b00;
`endif
        run_first_cell(9'h000, 9'h001, 9'h1FF, 2'b00, 2'b11, m, dr, ii, jj, w, s);
        total++;
        if (!s || m !== em || dr !== ed) begin
            bad++;
            $display("FAIL tie_diag: got max=%h dir=%b want max=%h dir=%b", m, dr, em, ed);
        end
    endtask

    task automatic test_dir_select();
        logic [8:0] m; logic [1:0] dr; logic [3:0] ii, jj; int w; bit s;
        // d=-1 u=3 l=-2
        run_first_cell(9'h000, 9'h005, 9'h000, 2'b10, 2'b01, m, dr, ii, jj, w, s);
        total++;
        if (!s || m !== 9'd3 || dr !== 2'b01) begin
            bad++;
            $display("FAIL up_wins: got max=%h dir=%b want max=003 dir=01", m, dr);
        end
        // d=1 u=-2 l=5
        run_first_cell(9'h000, 9'h000, 9'h007, 2'b11, 2'b11, m, dr, ii, jj, w, s);
        total++;
        if (!s || m !== 9'd5 || dr !== 2'b10) begin
            bad++;
            $display("FAIL left_wins: got max=%h dir=%b want max=005 dir=10", m, dr);
        end
        // d=-11 u=2 l=2 : up beats left on a tie
        run_first_cell(9'h1F6, 9'h004, 9'h004, 2'b00, 2'b01, m, dr, ii, jj, w, s);
        total++;
        if (!s || m !== 9'd2 || dr !== 2'b01) begin
            bad++;
            $display("FAIL tie_up_left: got max=%h dir=%b want max=002 dir=01", m, dr);
        end
    endtask

    task automatic test_saturation();
        logic [8:0] m; logic [1:0] dr; logic [3:0] ii, jj; int w; bit s;
        logic [8:0] em; logic [1:0] ed;
`ifdef NW_LOCAL_ALIGN_EN
        em = 9'h000; ed = 2'b11;
`else
        em = 9'h100; ed = 2'b00;
`endif
        run_first_cell(9'h100, 9'h100, 9'h100, 2'b00, 2'b10, m, dr, ii, jj, w, s);
        total++;
        if (!s || m !== em || dr !== ed) begin
            bad++;
            $display("FAIL sat_neg: got max=%h dir=%b want max=%h dir=%b", m, dr, em, ed);
        end
        run_first_cell(9'h0FF, 9'h000, 9'h000, 2'b10, 2'b10, m, dr, ii, jj, w, s);
        total++;
        if (!s || m !== 9'h0FF || dr !== 2'b00) begin
            bad++;
            $display("FAIL sat_pos: got max=%h dir=%b want max=0ff dir=00", m, dr);
        end
    endtask

    task automatic test_zero_result();
        logic [8:0] m; logic [1:0] dr; logic [3:0] ii, jj; int w; bit s;
        // d=0 exactly keeps the diag direction in both modes
        run_first_cell(9'h1FF, 9'h000, 9'h000, 2'b01, 2'b01, m, dr, ii, jj, w, s);
        total++;
        if (!s || m !== 9'h000 || dr !== 2'b00) begin
            bad++;
            $display("FAIL zero_result: got max=%h dir=%b want max=000 dir=00", m, dr);
        end
    endtask

    task automatic test_full_sweep();
        int wcount   = 0;
        int done_cyc = -1;
        int last_rd  = -10;
        bit busy_after = 1'b0;
        bus.diag = 9'h000; bus.up = 9'h1FE; bus.left = 9'h1FE;
        bus.char_a = 2'b10; bus.char_b = 2'b10;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (bus.en_read) last_rd = cyc;
            if (bus.we) begin
                total++;
                if (bus.i !== 4'(wcount / 4) || bus.j !== 4'(wcount % 4) || last_rd != cyc - 2
                    || bus.max !== 9'd1 || bus.dir !== 2'b00) begin
                    bad++;
                    $display("FAIL sweep_cell%0d: got i=%0d j=%0d max=%h rd@%0d we@%0d want i=%0d j=%0d max=001 rd@%0d",
                             wcount, bus.i, bus.j, bus.max, last_rd, cyc, wcount / 4, wcount % 4, cyc - 2);
                end
                wcount++;
            end
            if (done_cyc > 0 && cyc == done_cyc + 1 && bus.busy) busy_after = 1'b1;
            if (bus.done && done_cyc < 0) done_cyc = cyc;
            tick();
        end
        total++;
        if (wcount != 16) begin
            bad++;
            $display("FAIL sweep_we_count: got %0d want 16", wcount);
        end
        total++;
        if (done_cyc != 49) begin
            bad++;
            $display("FAIL sweep_done_cycle: got %0d want 49", done_cyc);
        end
        total++;
        if (busy_after !== 1'b0) begin
            bad++;
            $display("FAIL sweep_busy_after_done: got busy=1 want 0");
        end
    endtask

    task automatic test_ignore_start();
        int wcount   = 0;
        int done_cyc = -1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (bus.we) wcount++;
            if (bus.done && done_cyc < 0) done_cyc = cyc;
            bus.start = (cyc == 16);
            tick();
        end
        bus.start = 1'b0;
        total++;
        if (wcount != 16 || done_cyc != 49) begin
            bad++;
            $display("FAIL ignore_start: got we=%0d done@%0d want we=16 done@49", wcount, done_cyc);
        end
    endtask

    task automatic test_abort();
        bit late = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int cyc = 1; cyc < 20; cyc++) tick();
        #2;
        rst = 1'b0;
        #1;
        total++;
        if ({bus.en_read, bus.en_ins, bus.we, bus.dir_valid, bus.busy, bus.done} !== 6'b0
            || {bus.i, bus.j, bus.max, bus.dir} !== 19'b0) begin
            bad++;
            $display("FAIL abort_async: got i=%0d j=%0d max=%h dir=%b busy=%b want all 0",
                     bus.i, bus.j, bus.max, bus.dir, bus.busy);
        end
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (bus.done || bus.we || bus.busy) late = 1'b1;
        end
        total++;
        if (late !== 1'b0) begin
            bad++;
            $display("FAIL abort_no_resume: got activity=%b want 0", late);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.start  = 1'b0;
        bus.char_a = 2'b00;
        bus.char_b = 2'b00;
        bus.diag   = '0;
        bus.up     = '0;
        bus.left   = '0;
        test_reset();
        test_match();
        test_tie();
        test_dir_select();
        test_saturation();
        test_zero_result();
        test_full_sweep();
        test_ignore_start();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
